// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode 7-segment driver with debounced source-select button.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp7seg,
  input  logic [31:0] statJ,
  input  logic [31:0] statR,
  input  logic [31:0] statI,
  input  logic [31:0] statTC,
  input  logic        btn_mode,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  mode
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    digit;
  logic [31:0]   snapshot;
  logic [31:0]   selected;
  logic          sync_a;
  logic          sync_b;
  logic          btn_db;
  logic [DW-1:0] db_count;
  logic          mode_changed;
  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    hex;
  logic          digit_on;

  assign wrap = (prescaler == PRESC_MAX);

  always_comb begin
    selected = disp7seg;
    case (mode)
      3'd1:    selected = statJ;
      3'd2:    selected = statR;
      3'd3:    selected = statI;
      3'd4:    selected = statTC;
      default: selected = disp7seg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digit     <= 3'd0;
    end else if (wrap) begin
      prescaler <= '0;
      digit     <= digit + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Snapshot only moves at frame start or just after a mode change, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset)
      snapshot <= 32'd0;
    else if (mode_changed || (wrap && digit == 3'd7))
      snapshot <= selected;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a       <= 1'b0;
      sync_b       <= 1'b0;
      btn_db       <= 1'b0;
      db_count     <= '0;
      mode         <= 3'd0;
      mode_changed <= 1'b0;
    end else begin
      sync_a       <= btn_mode;
      sync_b       <= sync_a;
      mode_changed <= 1'b0;
      if (sync_b == btn_db) begin
        db_count <= '0;
      end else if (db_count == DB_MAX) begin
        db_count <= '0;
        btn_db   <= sync_b;
        if (sync_b) begin
          mode         <= (mode == 3'd4) ? 3'd0 : mode + 3'd1;
          mode_changed <= 1'b1;
        end
      end else begin
        db_count <= db_count + 1'b1;
      end
    end
  end

  assign nibble = snapshot[{digit, 2'b00} +: 4];

  always_comb begin
    hex = 7'h7F;
    case (nibble)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      4'hF: hex = 7'b0001110;
      default: hex = 7'h7F;
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [2:0] top_digit;

  // Digit 0 is always lit; higher digits only up to the most significant non-zero nibble.
  always_comb begin
    top_digit = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (snapshot[4*i +: 4] != 4'd0)
        top_digit = 3'(i);
    end
  end

  assign digit_on = (digit <= top_digit);
`else
  assign digit_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= digit_on ? ~(8'b1 << digit) : 8'hFF;
      seg <= digit_on ? hex : 7'h7F;
      dp  <= (digit == mode) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected digits per frame,
// a negedge monitor pops one entry each time the displayed digit changes.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] disp7seg, statJ, statR, statI, statTC;
  logic        btn_mode;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  mode;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
    .clk(clk), .reset(reset), .disp7seg(disp7seg), .statJ(statJ), .statR(statR),
    .statI(statI), .statTC(statTC), .btn_mode(btn_mode),
    .an(an), .seg(seg), .dp(dp), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         digit;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_out = 16'hFFFF;

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: a new digit presented is the "valid" event that retires one queue entry.
  always @(negedge clk) begin
    if (reset) begin
      last_out = {8'hFF, 7'h7F, 1'b1};
    end else begin
      if ({an, seg, dp} !== last_out && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          errors++;
          $display("[TB] FAIL digit%0d: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                   e.digit, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
      last_out = {an, seg, dp};
    end
  end

  task automatic waitAn(input logic [7:0] target, input string name);
    int found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk); #1;
      if (an === target) found = 1;
    end
    checkOutput(name, found, 1);
  endtask

  // Waits for the last digit of the current frame, then queues the whole next frame.
  task automatic pushFrame(input logic [31:0] value, input logic [2:0] sel);
    int found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && an === 8'h7F) found = 1;
    end
    checkOutput("frame_sync", found, 1);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.an    = ~(8'b1 << i);
      e.seg   = hexSeg(value[4*i +: 4]);
      e.dp    = (i == int'(sel)) ? 1'b0 : 1'b1;
      e.digit = i;
      exp_q.push_back(e);
    end
  endtask

  task automatic drainQueue();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input int high_clks, input int low_clks, input int reps);
    for (int r = 0; r < reps; r++) begin
      btn_mode = 1'b1;
      repeat (high_clks) @(negedge clk);
      btn_mode = 1'b0;
      repeat (low_clks) @(negedge clk);
    end
  endtask

  function automatic int idxOf(input logic [7:0] a);
    int idx = 0;
    for (int i = 0; i < 8; i++) if (a[i] == 1'b0) idx = i;
    return idx;
  endfunction

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int idx;
    disp7seg = 32'h1234ABCD;
    statJ    = 32'h00000005;
    statR    = 32'h89ABCDEF;
    statI    = 32'h13572468;
    statTC   = 32'hCAFE0042;
    btn_mode = 1'b0;
    reset    = 1'b1;

    $display("[TB] reset for 3 cycles");
    repeat (3) @(negedge clk);
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_seg", seg, 7'h7F);
    checkOutput("reset_dp", dp, 1'b1);
    checkOutput("reset_mode", mode, 3'd0);
    reset = 1'b0;

    $display("[TB] scan disp7seg, then change it mid-frame");
    pushFrame(32'h1234ABCD, 3'd0);
    waitAn(8'hEF, "midframe_sync");
    disp7seg = 32'h87654321;
    pushFrame(32'h87654321, 3'd0);
    drainQueue();

    $display("[TB] long press selects statJ");
    btn_mode = 1'b1;
    repeat (9) @(negedge clk);
    checkOutput("mode_before_debounce", mode, 3'd0);
    @(negedge clk);
    checkOutput("mode_after_debounce", mode, 3'd1);
    repeat (2) @(negedge clk);
    idx = idxOf(an);
    checkOutput("reload_seg", seg, hexSeg(statJ[4*idx +: 4]));
    checkOutput("reload_dp", dp, (idx == 1) ? 1'b0 : 1'b1);
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mode_once", mode, 3'd1);
    pushFrame(statJ, 3'd1);
    drainQueue();

    $display("[TB] short glitches on the button");
    applyStimulus(5, 5, 4);
    repeat (15) @(negedge clk);
    checkOutput("mode_glitch", mode, 3'd1);

    $display("[TB] clean presses through the sources");
    applyStimulus(12, 12, 1);
    checkOutput("mode_press2", mode, 3'd2);
    applyStimulus(12, 12, 1);
    checkOutput("mode_press3", mode, 3'd3);
    applyStimulus(12, 12, 1);
    checkOutput("mode_press4", mode, 3'd4);
    pushFrame(statTC, 3'd4);
    drainQueue();
    disp7seg = 32'h000000F0;
    applyStimulus(12, 12, 1);
    checkOutput("mode_wrap", mode, 3'd0);

    $display("[TB] small value 000000F0");
`ifdef SEG7_LZ_BLANK_EN
    waitAn(8'h7F, "lz_frame_sync");
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checkOutput("lz_high_off", an[7:2], 6'h3F);
      if (an === 8'hFE) checkOutput("lz_digit0", seg, 7'b1000000);
      if (an === 8'hFD) checkOutput("lz_digit1", seg, 7'b0001110);
    end
`else
    pushFrame(32'h000000F0, 3'd0);
    drainQueue();
`endif

    $display("[TB] reset mid-frame");
    waitAn(8'hFD, "midreset_sync");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_an", an, 8'hFF);
    checkOutput("midreset_seg", seg, 7'h7F);
    checkOutput("midreset_dp", dp, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_an", an, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
